// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//
// Purpose:
//   Receive side of the stopwatch's 4-digit multiplexed 7-segment display bus.
//   It listens on the same AN/seg/dot nets as the display and does not drive
//   them. For each complete scan it rebuilds the shown time as BCD digits and
//   as a total in tenths of a second. It then offers the result as one frame
//   over a valid/ready handshake.
//
// Parameters:
//   STABLE_CYCLES   consecutive identical synchronized samples needed before
//                   a digit slot is accepted
//   TIMEOUT_CYCLES  cycles allowed in COLLECT before the scan is declared lost
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   an_in[3:0]   anode lines, active-low one-hot
//                (1110 tenths, 1101 sec0, 1011 sec1, 0111 min)
//   seg_in[6:0]  segment lines, active-low, bit0=a .. bit6=g
//   dot_in       decimal point, active-low
//   frame_ready  consumer takes the frame when frame_valid && frame_ready
//   frame_valid  frame outputs valid, held until accepted
//   min/sec1/sec0/tenths  decoded BCD digits (4'hF when undecodable)
//   total_tenths min*600 + sec1*100 + sec0*10 + tenths, 0 for a bad frame
//   dot_mask     raw captured dot per slot, [0]=tenths .. [3]=min
//   frame_bad    at least one slot was undecodable or out of range
//   overrun      1-cycle pulse, completed frame dropped (output still held)
//   scan_lost    1-cycle pulse, COLLECT timed out
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an_in,
  input  logic [6:0]  seg_in,
  input  logic        dot_in,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [3:0]  min,
  output logic [3:0]  sec1,
  output logic [3:0]  sec0,
  output logic [3:0]  tenths,
  output logic [12:0] total_tenths,
  output logic [3:0]  dot_mask,
  output logic        frame_bad,
  output logic        overrun,
  output logic        scan_lost
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SCW-1:0] STABLE_MAX  = SCW'(STABLE_CYCLES);
  localparam logic [TOW-1:0] TIMEOUT_MAX = TOW'(TIMEOUT_CYCLES);

  // The idle bus value (all lines released) is used as the reset value of
  // the synchronizer and of the previous-sample register.
  localparam logic [11:0] IDLE_SAMPLE = 12'hFFF;

  typedef enum logic {
    ST_SYNC,
    ST_COLLECT
  } state_t;

  // Synchronizer stages
  logic [3:0]       an_meta_q, an_meta_d, an_sync_q, an_sync_d;
  logic [6:0]       seg_meta_q, seg_meta_d, seg_sync_q, seg_sync_d;
  logic             dot_meta_q, dot_meta_d, dot_sync_q, dot_sync_d;

  // Stability tracking
  logic [11:0]      cur_sample;
  logic [11:0]      prev_q, prev_d;
  logic [SCW-1:0]   stab_cnt_q, stab_cnt_d;
  logic             armed_q, armed_d;
  logic             an_onehot;
  logic [1:0]       slot;
  logic             accept;

  // Segment decode of the current sample
  logic [3:0]       dec_digit;
  logic             dec_bad;
  logic             slot_bad;

  // Frame assembly
  state_t           state_q, state_d;
  logic [3:0][3:0]  sh_digit_q, sh_digit_d;
  logic [3:0]       sh_dot_q, sh_dot_d;
  logic [3:0]       sh_bad_q, sh_bad_d;
  logic [3:0]       mask_q, mask_d;
  logic [TOW-1:0]   tmo_q, tmo_d;
  logic [TOW-1:0]   tmo_inc;
  logic [12:0]      sum_tenths;

  // Output registers
  logic             frame_valid_q, frame_valid_d;
  logic [3:0]       min_q, min_d;
  logic [3:0]       sec1_q, sec1_d;
  logic [3:0]       sec0_q, sec0_d;
  logic [3:0]       tenths_q, tenths_d;
  logic [12:0]      total_q, total_d;
  logic [3:0]       dot_mask_q, dot_mask_d;
  logic             frame_bad_q, frame_bad_d;
  logic             overrun_q, overrun_d;
  logic             scan_lost_q, scan_lost_d;

  // Maps an active-low segment pattern to {bad, digit}.
  // Unknown patterns return bad with digit 4'hF.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  // Two-flop synchronizer on every bus line before any logic sees it
  always_comb begin
    an_meta_d  = an_in;
    seg_meta_d = seg_in;
    dot_meta_d = dot_in;
    an_sync_d  = an_meta_q;
    seg_sync_d = seg_meta_q;
    dot_sync_d = dot_meta_q;
  end

  // Slot identification from the synchronized anodes.
  // Only a single low anode identifies a slot.
  always_comb begin
    an_onehot = 1'b1;
    slot      = 2'd0;
    case (an_sync_q)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: an_onehot = 1'b0;
    endcase
  end

  // Stability counter and acceptance.
  // The counter saturates at the threshold, so a long dwell does not wrap it.
  // The armed flag lets a slot be accepted only once per anode dwell. It is
  // re-armed only when the anode pattern changes, so a segment glitch inside
  // a slot cannot cause a second acceptance.
  always_comb begin
    cur_sample = {an_sync_q, seg_sync_q, dot_sync_q};
    prev_d     = cur_sample;
    stab_cnt_d = SCW'(1);
    if (an_onehot && (cur_sample == prev_q)) begin
      if (stab_cnt_q == STABLE_MAX) begin
        stab_cnt_d = stab_cnt_q;
      end else begin
        stab_cnt_d = stab_cnt_q + SCW'(1);
      end
    end
    accept  = armed_q && an_onehot && (stab_cnt_d == STABLE_MAX);
    armed_d = armed_q;
    if (an_sync_q != prev_q[11:8]) begin
      armed_d = 1'b1;
    end
    if (accept) begin
      armed_d = 1'b0;
    end
  end

  // Digit decode.
  // The tens-of-seconds digit can only be 0-5, so 6-9 in that slot also
  // marks the frame bad.
  always_comb begin
    {dec_bad, dec_digit} = decode_seg(seg_sync_q);
    slot_bad = dec_bad || ((slot == 2'd2) && (dec_digit > 4'd5));
  end

  // Weighted sum of the shadow digits, used only in the publish cycle
  always_comb begin
    sum_tenths = 13'(sh_digit_q[3]) * 13'd600
               + 13'(sh_digit_q[2]) * 13'd100
               + 13'(sh_digit_q[1]) * 13'd10
               + 13'(sh_digit_q[0]);
  end

  // Frame assembly FSM and output handshake.
  // SYNC waits for a tenths acceptance so that every frame starts at the
  // same slot. COLLECT fills the shadow registers until all four slots are
  // seen, then publishes. Publishing has priority over the timeout.
  always_comb begin
    state_d       = state_q;
    sh_digit_d    = sh_digit_q;
    sh_dot_d      = sh_dot_q;
    sh_bad_d      = sh_bad_q;
    mask_d        = mask_q;
    tmo_d         = tmo_q;
    tmo_inc       = tmo_q + TOW'(1);
    frame_valid_d = frame_valid_q;
    min_d         = min_q;
    sec1_d        = sec1_q;
    sec0_d        = sec0_q;
    tenths_d      = tenths_q;
    total_d       = total_q;
    dot_mask_d    = dot_mask_q;
    frame_bad_d   = frame_bad_q;
    overrun_d     = 1'b0;
    scan_lost_d   = 1'b0;

    // A consumed frame drops valid. A publish in the same cycle overrides it.
    if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end

    case (state_q)
      ST_SYNC: begin
        tmo_d = '0;
        if (accept && (slot == 2'd0)) begin
          sh_digit_d[0] = dec_digit;
          sh_dot_d[0]   = dot_sync_q;
          sh_bad_d      = {3'b000, slot_bad};
          mask_d        = 4'b0001;
          state_d       = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (mask_q == 4'b1111) begin
          // A held frame that is not being taken this cycle cannot be
          // replaced, so the new frame is dropped.
          if (!frame_valid_q || frame_ready) begin
            frame_valid_d = 1'b1;
            min_d         = sh_digit_q[3];
            sec1_d        = sh_digit_q[2];
            sec0_d        = sh_digit_q[1];
            tenths_d      = sh_digit_q[0];
            dot_mask_d    = sh_dot_q;
            frame_bad_d   = |sh_bad_q;
            total_d       = (|sh_bad_q) ? 13'd0 : sum_tenths;
          end else begin
            overrun_d = 1'b1;
          end
          mask_d  = 4'b0000;
          tmo_d   = '0;
          state_d = ST_SYNC;
        end else if (tmo_inc == TIMEOUT_MAX) begin
          scan_lost_d = 1'b1;
          sh_digit_d  = '0;
          sh_dot_d    = 4'b0000;
          sh_bad_d    = 4'b0000;
          mask_d      = 4'b0000;
          tmo_d       = '0;
          state_d     = ST_SYNC;
        end else begin
          tmo_d = tmo_inc;
          if (accept) begin
            sh_digit_d[slot] = dec_digit;
            sh_dot_d[slot]   = dot_sync_q;
            sh_bad_d[slot]   = slot_bad;
            mask_d[slot]     = 1'b1;
          end
        end
      end

      default: state_d = ST_SYNC;
    endcase
  end

  // All state registers. Reset loads the idle bus into the synchronizer and
  // clears everything else, so a frame in progress is simply dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_meta_q     <= 4'hF;
      an_sync_q     <= 4'hF;
      seg_meta_q    <= 7'h7F;
      seg_sync_q    <= 7'h7F;
      dot_meta_q    <= 1'b1;
      dot_sync_q    <= 1'b1;
      prev_q        <= IDLE_SAMPLE;
      stab_cnt_q    <= '0;
      armed_q       <= 1'b1;
      state_q       <= ST_SYNC;
      sh_digit_q    <= '0;
      sh_dot_q      <= 4'b0000;
      sh_bad_q      <= 4'b0000;
      mask_q        <= 4'b0000;
      tmo_q         <= '0;
      frame_valid_q <= 1'b0;
      min_q         <= 4'd0;
      sec1_q        <= 4'd0;
      sec0_q        <= 4'd0;
      tenths_q      <= 4'd0;
      total_q       <= 13'd0;
      dot_mask_q    <= 4'b0000;
      frame_bad_q   <= 1'b0;
      overrun_q     <= 1'b0;
      scan_lost_q   <= 1'b0;
    end else begin
      an_meta_q     <= an_meta_d;
      an_sync_q     <= an_sync_d;
      seg_meta_q    <= seg_meta_d;
      seg_sync_q    <= seg_sync_d;
      dot_meta_q    <= dot_meta_d;
      dot_sync_q    <= dot_sync_d;
      prev_q        <= prev_d;
      stab_cnt_q    <= stab_cnt_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      sh_digit_q    <= sh_digit_d;
      sh_dot_q      <= sh_dot_d;
      sh_bad_q      <= sh_bad_d;
      mask_q        <= mask_d;
      tmo_q         <= tmo_d;
      frame_valid_q <= frame_valid_d;
      min_q         <= min_d;
      sec1_q        <= sec1_d;
      sec0_q        <= sec0_d;
      tenths_q      <= tenths_d;
      total_q       <= total_d;
      dot_mask_q    <= dot_mask_d;
      frame_bad_q   <= frame_bad_d;
      overrun_q     <= overrun_d;
      scan_lost_q   <= scan_lost_d;
    end
  end

  assign frame_valid  = frame_valid_q;
  assign min          = min_q;
  assign sec1         = sec1_q;
  assign sec0         = sec0_q;
  assign tenths       = tenths_q;
  assign total_tenths = total_q;
  assign dot_mask     = dot_mask_q;
  assign frame_bad    = frame_bad_q;
  assign overrun      = overrun_q;
  assign scan_lost    = scan_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_decoder
//
// Purpose:
//   Directed bench for seg_scan_decoder. It drives scanned display patterns
//   and checks the rebuilt frames against hand-computed values. The timeout
//   is shortened so that the lost-scan case stays short.
// ---------------------------------------------------------------------------
module tb_seg_scan_decoder;

  localparam int TB_TIMEOUT = 200;

  logic        clk;
  logic        rst;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic        dot_in;
  logic        frame_ready;
  logic        frame_valid;
  logic [3:0]  min;
  logic [3:0]  sec1;
  logic [3:0]  sec0;
  logic [3:0]  tenths;
  logic [12:0] total_tenths;
  logic [3:0]  dot_mask;
  logic        frame_bad;
  logic        overrun;
  logic        scan_lost;

  int checkCount;
  int passCount;
  int acceptedFrames;
  int overrunPulses;
  int scanLostPulses;
  int accBase;
  int ovBase;
  int slBase;

  seg_scan_decoder #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .an_in        (an_in),
    .seg_in       (seg_in),
    .dot_in       (dot_in),
    .frame_ready  (frame_ready),
    .frame_valid  (frame_valid),
    .min          (min),
    .sec1         (sec1),
    .sec0         (sec0),
    .tenths       (tenths),
    .total_tenths (total_tenths),
    .dot_mask     (dot_mask),
    .frame_bad    (frame_bad),
    .overrun      (overrun),
    .scan_lost    (scan_lost)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts handshakes and event pulses on the falling edge. The directed
  // sequence can then check how many occurred over a stretch of stimulus.
  always @(negedge clk) begin
    if (frame_valid && frame_ready) acceptedFrames++;
    if (overrun) overrunPulses++;
    if (scan_lost) scanLostPulses++;
  end

  // Active-low segment pattern for a decimal digit, as the display drives it
  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Holds one bus value for a number of cycles.
  // Call it at a falling edge. It returns at a falling edge.
  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg,
                               input logic dot, input int cycles);
    an_in  = an;
    seg_in = seg;
    dot_in = dot;
    repeat (cycles) @(negedge clk);
  endtask

  // One full scan starting at the tenths slot, 8 cycles per slot.
  // dots[i] is the raw dot level for slot i.
  task automatic scanFrame(input int m, input int s1, input int s0, input int t,
                           input logic [3:0] dots);
    applyStimulus(4'b1110, segOf(t),  dots[0], 8);
    applyStimulus(4'b1101, segOf(s0), dots[1], 8);
    applyStimulus(4'b1011, segOf(s1), dots[2], 8);
    applyStimulus(4'b0111, segOf(m),  dots[3], 8);
  endtask

  // One comparison. Counts it and reports a miss.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Compares every frame output field against expected values
  task automatic checkFrame(input string tag, input int m, input int s1, input int s0,
                            input int t, input int total, input logic [3:0] dm,
                            input logic bad);
    checkOutput({tag, ".min"},    16'(min),          16'(m));
    checkOutput({tag, ".sec1"},   16'(sec1),         16'(s1));
    checkOutput({tag, ".sec0"},   16'(sec0),         16'(s0));
    checkOutput({tag, ".tenths"}, 16'(tenths),       16'(t));
    checkOutput({tag, ".total"},  16'(total_tenths), 16'(total));
    checkOutput({tag, ".dots"},   16'(dot_mask),     16'(dm));
    checkOutput({tag, ".bad"},    16'(frame_bad),    16'(bad));
  endtask

  // Directed sequence covering reset, normal scans, short dwell, bad
  // patterns, back-pressure, timeout and mid-frame reset
  initial begin
    checkCount     = 0;
    passCount      = 0;
    acceptedFrames = 0;
    overrunPulses  = 0;
    scanLostPulses = 0;
    rst         = 1'b0;
    an_in       = 4'hF;
    seg_in      = 7'h7F;
    dot_in      = 1'b1;
    frame_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst.valid",   16'(frame_valid), 16'd0);
    checkOutput("rst.overrun", 16'(overrun),     16'd0);
    checkOutput("rst.lost",    16'(scan_lost),   16'd0);
    checkFrame("rst", 0, 0, 0, 0, 0, 4'b0000, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] scan 3:47.2 with ready high");
    accBase = acceptedFrames;
    scanFrame(3, 4, 7, 2, 4'b1111);
    checkOutput("s1.frames", 16'(acceptedFrames - accBase), 16'd1);
    checkOutput("s1.valid_dropped", 16'(frame_valid), 16'd0);
    checkFrame("s1", 3, 4, 7, 2, 2272, 4'b1111, 1'b0);

    $display("[TB] short sec0 dwell gives no frame");
    accBase = acceptedFrames;
    applyStimulus(4'b1110, segOf(2), 1'b1, 8);
    applyStimulus(4'b1101, segOf(7), 1'b1, 2);
    applyStimulus(4'b1011, segOf(4), 1'b1, 8);
    applyStimulus(4'b0111, segOf(3), 1'b1, 8);
    checkOutput("short.frames", 16'(acceptedFrames - accBase), 16'd0);
    // Completing the pending frame and then a fresh scan with new digits
    scanFrame(3, 4, 7, 2, 4'b1111);
    checkOutput("short.later_frames", 16'(acceptedFrames - accBase), 16'd1);
    scanFrame(5, 0, 9, 8, 4'b1111);
    checkOutput("s2.frames", 16'(acceptedFrames - accBase), 16'd2);
    checkFrame("s2", 5, 0, 9, 8, 3098, 4'b1111, 1'b0);

    $display("[TB] undecodable sec0 and a lit dot on sec1");
    applyStimulus(4'b1110, segOf(1), 1'b1, 8);
    applyStimulus(4'b1101, 7'b1111111, 1'b1, 8);
    applyStimulus(4'b1011, segOf(2), 1'b0, 8);
    applyStimulus(4'b0111, segOf(0), 1'b1, 8);
    checkFrame("bad", 0, 2, 15, 1, 0, 4'b1011, 1'b1);

    $display("[TB] sec1 out of range");
    scanFrame(0, 7, 9, 0, 4'b1111);
    checkFrame("range", 0, 7, 9, 0, 0, 4'b1111, 1'b1);

    $display("[TB] back-pressure: two scans with ready low");
    frame_ready = 1'b0;
    ovBase = overrunPulses;
    scanFrame(1, 2, 3, 4, 4'b1111);
    checkOutput("bp.valid1", 16'(frame_valid), 16'd1);
    checkFrame("bp.A", 1, 2, 3, 4, 834, 4'b1111, 1'b0);
    scanFrame(2, 3, 4, 5, 4'b1111);
    checkOutput("bp.valid2", 16'(frame_valid), 16'd1);
    checkOutput("bp.overruns", 16'(overrunPulses - ovBase), 16'd1);
    checkFrame("bp.held", 1, 2, 3, 4, 834, 4'b1111, 1'b0);
    frame_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.valid_drop", 16'(frame_valid), 16'd0);

    $display("[TB] scan lost after tenths");
    slBase = scanLostPulses;
    applyStimulus(4'b1110, segOf(6), 1'b1, 8);
    applyStimulus(4'hF, 7'h7F, 1'b1, TB_TIMEOUT + 50);
    checkOutput("lost.pulses", 16'(scanLostPulses - slBase), 16'd1);
    checkOutput("lost.valid",  16'(frame_valid), 16'd0);

    $display("[TB] reset after two slots");
    accBase = acceptedFrames;
    ovBase  = overrunPulses;
    applyStimulus(4'b1110, segOf(6), 1'b1, 8);
    applyStimulus(4'b1101, segOf(9), 1'b1, 8);
    an_in  = 4'hF;
    seg_in = 7'h7F;
    rst    = 1'b0;
    @(negedge clk);
    checkOutput("mrst.valid", 16'(frame_valid), 16'd0);
    checkFrame("mrst", 0, 0, 0, 0, 0, 4'b0000, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    scanFrame(4, 5, 9, 6, 4'b1111);
    checkOutput("mrst.frames",   16'(acceptedFrames - accBase), 16'd1);
    checkOutput("mrst.overruns", 16'(overrunPulses - ovBase),   16'd0);
    checkFrame("mrst.after", 4, 5, 9, 6, 2996, 4'b1111, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
